// File: rtl/alu_exec_stage.sv
`timescale 1ns/1ps
// Purpose: ALU execute stage; computes result/flags and registers them into the EX/MEM boundary.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: 2-entry main+skid buffer; in_ready = ~skid valid (register-driven), M held while ~out_ready.
//
// Ports:
//   clk, rst (async, active-low), flush (sync, active-high)
//   in_valid/in_ready, alu_control[2:0], src_a, src_b, in_rd, in_reg_write : upstream operation
//   out_valid/out_ready, alu_result, zero, negative, carry, overflow, out_rd, out_reg_write : EX/MEM
//
// Optional feature: define ALU_EXEC_EXT_OPS_EN to decode 100 XOR, 110 SLTU, 111 SRA-by-1.
// Without it those codes produce result 0 (zero=1).
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_reg_write
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b101;
`ifdef ALU_EXEC_EXT_OPS_EN
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SRA1 = 3'b111;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic [RD_W-1:0]  rd;
    logic             reg_write;
  } ex_dat_t;

  // ---------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  ex_dat_t          new_dat;

  // Both arithmetic paths are WIDTH+1 bits so bit WIDTH is the carry-out;
  // for subtract that carry is 1 when no borrow occurred.
  assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
  assign diff_ext = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

  assign add_ovf = (src_a[MSB] == src_b[MSB]) & (sum_ext[MSB]  != src_a[MSB]);
  assign sub_ovf = (src_a[MSB] != src_b[MSB]) & (diff_ext[MSB] != src_a[MSB]);

  // Signed less-than: sign of the difference corrected by overflow.
  assign slt_bit = diff_ext[MSB] ^ sub_ovf;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_control)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = sub_ovf;
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
`ifdef ALU_EXEC_EXT_OPS_EN
      OP_XOR:  alu_res = src_a ^ src_b;
      // Unsigned borrow of the subtract is exactly a < b.
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~diff_ext[WIDTH]};
      OP_SRA1: alu_res = {src_a[MSB], src_a[WIDTH-1:1]};
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    new_dat           = '0;
    new_dat.result    = alu_res;
    new_dat.zero      = (alu_res == '0);
    new_dat.negative  = alu_res[MSB];
    new_dat.carry     = alu_carry;
    new_dat.overflow  = alu_ovf;
    new_dat.rd        = in_rd;
    new_dat.reg_write = in_reg_write;
  end

  // ---------------------------------------------------------------
  // Main (M) + skid (S) storage
  // ---------------------------------------------------------------
  logic    m_vld;
  logic    s_vld;
  ex_dat_t m_dat;
  ex_dat_t s_dat;
  logic    accept;
  logic    drain;
  logic    m_free;

  assign in_ready = ~s_vld;
  assign accept   = in_valid & in_ready;
  assign drain    = m_vld & out_ready;
  // M can take a new entry this cycle if it is empty or being consumed.
  assign m_free   = ~m_vld | drain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else if (flush) begin
      // Payloads are left as-is; only the valid bits matter once invalid.
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (m_free) begin
      if (s_vld) begin
        // Older skid entry moves forward first; in_ready is low so no accept.
        m_vld <= 1'b1;
        m_dat <= s_dat;
        s_vld <= 1'b0;
      end else if (accept) begin
        m_vld <= 1'b1;
        m_dat <= new_dat;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (accept) begin
      // M stalled: park the new op in S, which drops in_ready next cycle.
      s_vld <= 1'b1;
      s_dat <= new_dat;
    end
  end

  assign out_valid     = m_vld;
  assign alu_result    = m_dat.result;
  assign zero          = m_dat.zero;
  assign negative      = m_dat.negative;
  assign carry         = m_dat.carry;
  assign overflow      = m_dat.overflow;
  assign out_rd        = m_dat.rd;
  assign out_reg_write = m_dat.reg_write;

endmodule

// File: tb/tb_alu_exec_stage.sv
`timescale 1ns/1ps
// Bench for alu_exec_stage: directed scenarios followed by randomized traffic,
// checked against an arithmetic reference model and an in-order queue of
// accepted operations.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  alu_exec_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_control   (alu_control),
    .src_a         (src_a),
    .src_b         (src_b),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .zero          (zero),
    .negative      (negative),
    .carry         (carry),
    .overflow      (overflow),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t        q[$];        // operations accepted and not yet consumed, oldest first
  logic [31:0] drained[$];  // results observed leaving the stage
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the operands.
  function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd,
                                  input logic rw);
    exp_t                e;
    longint              sa;
    longint              sb;
    longint              t;
    longint unsigned     ua;
    longint unsigned     ub;
    longint unsigned     u;
    logic signed [31:0]  lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.res = 32'd0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    case (op)
      3'd0: begin
        u = ua + ub;
        e.res = u[31:0];
        e.c = u[32];
        t = sa + sb;
        lo = t[31:0];
        e.v = (t != longint'(lo));
      end
      3'd1: begin
        e.res = a - b;
        e.c = (ua >= ub);
        t = sa - sb;
        lo = t[31:0];
        e.v = (t != longint'(lo));
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_EXT_OPS_EN
      3'd4: e.res = a ^ b;
      3'd6: e.res = (ua < ub) ? 32'd1 : 32'd0;
      3'd7: begin
        t = sa >>> 1;
        e.res = t[31:0];
      end
`endif
      default: e.res = 32'd0;
    endcase
    e.z  = (e.res == 32'd0);
    e.n  = e.res[31];
    e.rd = rd;
    e.rw = rw;
    return e;
  endfunction

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("alu_result", alu_result, q[0].res);
      chk("zero", 32'(zero), 32'(q[0].z));
      chk("negative", 32'(negative), 32'(q[0].n));
      chk("carry", 32'(carry), 32'(q[0].c));
      chk("overflow", 32'(overflow), 32'(q[0].v));
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_reg_write", 32'(out_reg_write), 32'(q[0].rw));
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic ordy, input logic fl);
    logic acc;
    logic drn;
    exp_t e;
    in_valid     = v;
    alu_control  = op;
    src_a        = a;
    src_b        = b;
    in_rd        = 5'($urandom);
    in_reg_write = 1'($urandom);
    out_ready    = ordy;
    flush        = fl;
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    e = ref_op(op, a, b, in_rd, in_reg_write);
    if (out_valid && ordy && !fl) drained.push_back(alu_result);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    check_state();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_control = 3'd0;
    src_a = '0; src_b = '0; in_rd = '0; in_reg_write = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_flags", {28'd0, zero, negative, carry, overflow}, 32'd0);
    chk("rst_rd_we", {26'd0, out_rd, out_reg_write}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // ADD signed overflow
    step(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
    chk("add_result", alu_result, 32'h8000_0000);
    chk("add_flags_zncv", {28'd0, zero, negative, carry, overflow}, 32'b0101);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // SUB equal operands
    step(1'b1, 3'd1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
    chk("sub_result", alu_result, 32'd0);
    chk("sub_flags_zncv", {28'd0, zero, negative, carry, overflow}, 32'b1010);

    // SLT both orders
    step(1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    chk("slt_lt", alu_result, 32'd1);
    step(1'b1, 3'd5, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("slt_ge", alu_result, 32'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Backpressure: three back-to-back ADDs against a stalled consumer
    drained.delete();
    step(1'b1, 3'd0, 32'd1, 32'd1, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd2, 32'd2, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step(1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd3, 32'd3, 1'b1, 1'b0);
    step(1'b1, 3'd0, 32'd3, 32'd3, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_count", 32'(drained.size()), 32'd3);
    if (drained.size() == 3) begin
      chk("bp_first", drained[0], 32'd2);
      chk("bp_second", drained[1], 32'd4);
      chk("bp_third", drained[2], 32'd6);
    end

    // Flush with both entries full and a concurrent op
    drained.delete();
    step(1'b1, 3'd0, 32'd10, 32'd10, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd20, 32'd20, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd30, 32'd30, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (3) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_nothing_out", 32'(drained.size()), 32'd0);

    // Asynchronous reset between edges
    step(1'b1, 3'd0, 32'd5, 32'd5, 1'b0, 1'b0);
    chk("pre_arst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_result", alu_result, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Optional opcodes
`ifdef ALU_EXEC_EXT_OPS_EN
    step(1'b1, 3'd4, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 1'b0);
    chk("xor_result", alu_result, 32'h0000_FF00);
    step(1'b1, 3'd6, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("sltu_result", alu_result, 32'd1);
`else
    step(1'b1, 3'd4, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 1'b0);
    chk("op100_result", alu_result, 32'd0);
    chk("op100_zero", 32'(zero), 32'd1);
`endif
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(3) != 0), 3'($urandom_range(7)), pick(), pick(),
           1'($urandom_range(2) != 0), 1'($urandom_range(40) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage sitting directly downstream of the ALU control decoder.
- Consumes the 3-bit ALU control code plus operands, and computes the result and flags.
- Registers the outcome into the EX/MEM boundary with a valid/ready handshake.
- A 2-entry skid buffer absorbs one cycle of downstream backpressure, so in_ready is driven purely from a register.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 8).
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous pipeline flush, active-high.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_control  input  3  operation code from the ALU control decoder.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B (register or immediate, already muxed).
- in_rd  input  RD_W  destination register index.
- in_reg_write  input  1  writeback enable.
- out_valid  output  1  result register holds a valid operation.
- out_ready  input  1  downstream accepts the result.
- alu_result  output  WIDTH  registered result.
- zero  output  1  alu_result == 0.
- negative  output  1  alu_result[WIDTH-1].
- carry  output  1  adder carry-out.
- overflow  output  1  signed overflow of add/sub.
- out_rd  output  RD_W  registered destination index.
- out_reg_write  output  1  registered writeback enable.

Behaviour:
- Reset (rst low, asynchronous):
  - Main and skid entries are cleared.
  - out_valid=0; alu_result, zero, negative, carry, overflow, out_rd and out_reg_write are all 0.
  - in_ready=1 (skid empty).
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND.
  - 011 OR.
  - 101 SLT: signed a<b gives result 1, otherwise 0; zero-extended to WIDTH.
  - 100, 110, 111: result 0 (unless the optional feature is enabled).
- Flags:
  - carry = bit WIDTH of the WIDTH+1-bit adder for ADD/SUB; on SUB, 1 means no borrow. carry is 0 for all other opcodes.
  - overflow for ADD = (a[msb]==b[msb]) & (sum[msb]!=a[msb]).
  - overflow for SUB = (a[msb]!=b[msb]) & (diff[msb]!=a[msb]).
  - overflow is 0 for all other opcodes.
  - SLT compare uses diff[msb]^overflow of the subtract.
  - zero and negative are computed from the final result.
- Computation is combinational on the inputs. All outputs are registered: latency is 1 cycle from an accepted input (in_valid & in_ready) to out_valid.
- Storage: main entry M (drives the outputs) and skid entry S. in_ready = ~S.valid, registered.
- Each cycle, let accept = in_valid & in_ready and drain = out_valid & out_ready.
  - M empty or drain, S empty: M <- new if accept, else M.valid <- 0.
  - M empty or drain, S full: M <- S, S <- empty. in_ready is 0 this cycle, so accept cannot happen.
  - M full and no drain: if accept, S <- new, and in_ready drops next cycle.
- No operation is lost or duplicated. Order is preserved (M before S).
- M payload is held stable while out_valid & ~out_ready.
- flush has priority over everything except reset:
  - At the clock edge, M.valid and S.valid clear and any accept in that cycle is dropped.
  - in_ready=1 the next cycle.
  - Payload registers are don't-care when invalid, but the bench checks valid bits only.
- Reset mid-operation: all in-flight entries are discarded immediately and asynchronously.
- Arithmetic wraps modulo 2^WIDTH.

Optional Feature:
- Macro: ALU_EXEC_EXT_OPS_EN.
- Defined: decodes additional opcodes.
  - 100 XOR.
  - 110 SLTU: unsigned a<b gives 1; this equals ~carry of the subtract.
  - 111 SRA-by-1: arithmetic shift right of src_a by one.
  - carry and overflow are 0 for these opcodes.
- Undefined: 100, 110 and 111 produce result 0 and zero=1.

Test Plan:
- Reset then ADD:
  - Hold rst=0 and check out_valid=0, in_ready=1, all outputs 0.
  - Release, then send ADD a=0x7FFFFFFF, b=1 with out_ready=1.
  - Next cycle: result=0x80000000, overflow=1, negative=1, carry=0, zero=0.
- SUB equal operands: a=b=0x12345678.
  - Result=0, zero=1, carry=1, overflow=0.
- SLT: a=0xFFFFFFFF (-1), b=1 gives result=1.
  - Swapped operands give result=0.
- Backpressure:
  - Hold out_ready=0 and issue 3 back-to-back ADDs (1+1, 2+2, 3+3).
  - Ops 1 and 2 are accepted; in_ready drops after op 2; op 3 is held by upstream.
  - Raise out_ready: results emerge in order 2, 4, 6 with no gaps or duplicates.
- Flush:
  - With M and S full, assert flush together with in_valid.
  - Next cycle: out_valid=0, in_ready=1, and the flushed and concurrent ops never appear.
- Async reset mid-stream:
  - Drop rst between clock edges while out_valid=1.
  - out_valid clears immediately, before the next edge.
  - With ALU_EXEC_EXT_OPS_EN defined: XOR 0xF0F0 ^ 0x0FF0 = 0xFF00, and SLTU 1 < 0xFFFFFFFF gives 1.
